// File: rtl/sar_conv_ctrl.sv
// Conversion sequencer for an asynchronous SAR ADC macro: sampling window, timed
// conversion with abort, and a single-entry valid/ready result register.
module sar_conv_ctrl #(
  parameter int unsigned ADC_BITS       = 8,
  parameter int unsigned SAMPLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cont_en,
  input  logic                compl,
  input  logic [0:ADC_BITS-1] adc_data,
  output logic                sample,
  output logic                adc_rst,
  output logic                busy,
  output logic [ADC_BITS-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                err_timeout,
  output logic                err_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT,
    CAPTURE
  } state_t;

  localparam logic [CNT_W-1:0] SAMPLE_LAST  = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       sync;
  logic             compl_s;
  logic             timeout_next;
  logic             capture;
  logic             overrun;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], compl};
    end
  end

  assign compl_s = sync[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    timeout_next = 1'b0;
    sample       = 1'b0;
    adc_rst      = 1'b0;
    busy         = 1'b1;
    unique case (state)
      IDLE: begin
        adc_rst  = 1'b1;
        busy     = 1'b0;
        cnt_next = '0;
        if (start || cont_en) state_next = SAMPLE;
      end
      SAMPLE: begin
        sample  = 1'b1;
        adc_rst = 1'b1;
        if (cnt == SAMPLE_LAST) begin
          state_next = CONVERT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      CONVERT: begin
        // End-of-conversion wins over a timeout landing on the same edge.
        if (compl_s) begin
          state_next = CAPTURE;
          cnt_next   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next   = IDLE;
          cnt_next     = '0;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      CAPTURE: begin
        cnt_next   = '0;
        state_next = cont_en ? SAMPLE : IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign capture = (state == CAPTURE);
  assign overrun = capture && out_valid && !out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data    <= '0;
      out_valid   <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_timeout <= timeout_next;
      err_overrun <= overrun;
      if (capture && !overrun) begin
        // Positional copy: adc_data[0] (MSB) lands in out_data[ADC_BITS-1].
        out_data  <= adc_data;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Bench for sar_conv_ctrl: directed vector table, hand sequences for mode/reset corners,
// and randomized one-shot conversions checked against a timing/handshake model.
module tb_sar_conv_ctrl;

  localparam int unsigned AB = 8;
  localparam int unsigned SC = 4;
  localparam int unsigned TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          cont_en = 1'b0;
  logic          compl = 1'b0;
  logic [0:AB-1] adc_data = '0;
  logic          out_ready = 1'b0;
  logic          sample, adc_rst, busy, out_valid, err_timeout, err_overrun;
  logic [AB-1:0] out_data;

  int total = 0;
  int bad   = 0;

  logic       m_valid;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  sar_conv_ctrl #(
    .ADC_BITS(AB),
    .SAMPLE_CYCLES(SC),
    .TIMEOUT_CYCLES(TO),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cont_en(cont_en),
    .compl(compl),
    .adc_data(adc_data),
    .sample(sample),
    .adc_rst(adc_rst),
    .busy(busy),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  typedef struct {
    logic [7:0] data;
    int         d;
    bit         rdy;
    bit         late;
    int         exp_low;
    bit         exp_to;
    bit         exp_ov;
    bit         exp_valid;
    logic [7:0] exp_out;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after adc_rst rises again.
  task automatic run_conv(input logic [7:0] data, input int d, input bit rdy, input bit late,
                          output int low, output int smp, output logic to, output logic ov,
                          output logic valid, output logic [7:0] od, output logic bsy);
    int  early;
    bit  done;
    early = 0;
    done  = 0;
    low   = 0;
    smp   = 0;
    to = 1'bx; ov = 1'bx; valid = 1'bx; od = 'x; bsy = 1'bx;
    out_ready = rdy;
    adc_data  = data;
    start     = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (sample === 1'b1) smp++;
      if (adc_rst === 1'b0) begin
        low++;
        if (low == d + 1) compl = 1'b1;
        if (late && low == d + 4) out_ready = 1'b1;
        if (err_timeout === 1'b1 || err_overrun === 1'b1) early++;
      end else if (low > 0) begin
        done  = 1;
        compl = 1'b0;
        to    = err_timeout;
        ov    = err_overrun;
        valid = out_valid;
        od    = out_data;
        bsy   = busy;
      end
    end
    chk("conv_done_in_bound", 32'(done), 32'd1);
    chk("no_early_err", early, 0);
  endtask

  // Continue an already-started conversion; start_at pulses start while adc_rst is low.
  task automatic wait_convert(input logic [7:0] data, input int d, input bit drop_cont,
                              input int start_at, output int low);
    bit done;
    done = 0;
    low  = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (adc_rst === 1'b0) begin
        low++;
        if (low == 1) begin
          adc_data = data;
          if (drop_cont) cont_en = 1'b0;
        end
        start = (low == start_at);
        if (low == d + 1) compl = 1'b1;
      end else if (low > 0) begin
        compl = 1'b0;
        start = 1'b0;
        done  = 1;
      end
    end
    chk("wait_convert_bound", 32'(done), 32'd1);
  endtask

  // Reference: capture happens iff the synchronized flag reaches the FSM by the last timeout cycle.
  task automatic model_step(input logic [7:0] data, input int d, input bit rdy, input bit late,
                            output int exp_low, output bit exp_to, output bit exp_ov);
    bit capt;
    bit rdy_cap;
    capt    = (d + 3 <= int'(TO));
    rdy_cap = rdy || late;
    exp_low = capt ? d + 4 : int'(TO);
    exp_to  = !capt;
    if (rdy) m_valid = 1'b0;
    exp_ov = capt && m_valid && !rdy_cap;
    if (capt && !exp_ov) begin
      m_valid = 1'b1;
      m_data  = data;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_sample", sample, 0);
    chk("rst_adc_rst", adc_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_err_overrun", err_overrun, 0);
    start = 1'b0; cont_en = 1'b0; compl = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  initial begin
    int         low, smp, el, ov_cnt, busy_cnt;
    logic       to, ov, valid, bsy;
    logic [7:0] od;
    bit         eto, eov;
    logic [7:0] vals[3];
    logic [7:0] rd;
    int         rdl;
    bit         rr, rl;

    tbl[0] = '{8'hA5, 10, 1'b0, 1'b0, 14, 1'b0, 1'b0, 1'b1, 8'hA5};
    tbl[1] = '{8'h3C,  2, 1'b0, 1'b0,  6, 1'b0, 1'b1, 1'b1, 8'hA5};
    tbl[2] = '{8'h3C, 61, 1'b1, 1'b0, 65, 1'b0, 1'b0, 1'b1, 8'h3C};
    tbl[3] = '{8'h00, 62, 1'b0, 1'b0, 64, 1'b1, 1'b0, 1'b1, 8'h3C};
    tbl[4] = '{8'h7E,  0, 1'b0, 1'b0,  4, 1'b0, 1'b1, 1'b1, 8'h3C};
    tbl[5] = '{8'h81,  5, 1'b1, 1'b0,  9, 1'b0, 1'b0, 1'b1, 8'h81};
    tbl[6] = '{8'h7E,  3, 1'b0, 1'b1,  7, 1'b0, 1'b0, 1'b1, 8'h7E};
    tbl[7] = '{8'hC3, 63, 1'b1, 1'b0, 64, 1'b1, 1'b0, 1'b0, 8'h7E};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      run_conv(tbl[i].data, tbl[i].d, tbl[i].rdy, tbl[i].late, low, smp, to, ov, valid, od, bsy);
      chk($sformatf("tbl%0d_adc_rst_low", i), low, tbl[i].exp_low);
      chk($sformatf("tbl%0d_sample_len", i), smp, SC);
      chk($sformatf("tbl%0d_err_timeout", i), to, tbl[i].exp_to);
      chk($sformatf("tbl%0d_err_overrun", i), ov, tbl[i].exp_ov);
      chk($sformatf("tbl%0d_out_valid", i), valid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_out_data", i), od, tbl[i].exp_out);
      chk($sformatf("tbl%0d_busy", i), bsy, 0);
    end
    @(negedge clk);
    chk("timeout_pulse_one_cycle", err_timeout, 0);
    chk("timeout_idle_busy", busy, 0);

    do_reset();
    for (int i = 0; i < 40; i++) begin
      rd  = 8'($urandom);
      rdl = int'($urandom_range(0, 70));
      rr  = 1'($urandom_range(0, 1));
      rl  = !rr && 1'($urandom_range(0, 1));
      model_step(rd, rdl, rr, rl, el, eto, eov);
      run_conv(rd, rdl, rr, rl, low, smp, to, ov, valid, od, bsy);
      chk($sformatf("rnd%0d_adc_rst_low", i), low, el);
      chk($sformatf("rnd%0d_sample_len", i), smp, SC);
      chk($sformatf("rnd%0d_err_timeout", i), to, eto);
      chk($sformatf("rnd%0d_err_overrun", i), ov, eov);
      chk($sformatf("rnd%0d_out_valid", i), valid, m_valid);
      chk($sformatf("rnd%0d_out_data", i), od, m_data);
      chk($sformatf("rnd%0d_busy", i), bsy, 0);
    end

    // Continuous mode with a stalled consumer.
    do_reset();
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    ov_cnt = 0;
    cont_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      wait_convert(vals[j], 3, j == 2, 0, low);
      chk($sformatf("cont%0d_adc_rst_low", j), low, 7);
      if (err_overrun === 1'b1) ov_cnt++;
      if (j < 2) chk($sformatf("cont%0d_resample", j), sample, 1);
    end
    chk("cont_overrun_count", ov_cnt, 2);
    chk("cont_out_data", out_data, 8'h11);
    chk("cont_out_valid", out_valid, 1);
    chk("cont_stop_busy", busy, 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("cont_consume_valid", out_valid, 0);

    // start pulses during SAMPLE and CONVERT must not queue a second conversion.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ign_in_sample", sample, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_convert(8'h96, 5, 1'b0, 2, low);
    chk("ign_out_valid", out_valid, 1);
    chk("ign_out_data", out_data, 8'h96);
    busy_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_cnt++;
    end
    chk("ign_single_conversion", busy_cnt, 0);

    // Asynchronous reset in the middle of CONVERT with a pending result.
    run_conv(8'h5A, 4, 1'b0, 1'b0, low, smp, to, ov, valid, od, bsy);
    chk("arst_pre_valid", valid, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (SC + 3) @(negedge clk);
    chk("arst_in_convert", adc_rst, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_adc_rst", adc_rst, 1);
    chk("arst_sample", sample, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err_timeout", err_timeout, 0);
    @(negedge clk);
    rst = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || adc_rst !== 1'b1) busy_cnt++;
    end
    chk("arst_stays_idle", busy_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sar_conv_ctrl.md
# sar_conv_ctrl

Synchronous conversion sequencer for the asynchronous SAR ADC macro (sample/hold front end plus capacitor-DAC/SAR-logic core). It sits on the digital clock domain. It runs the sampling window, releases the SAR core to convert, and waits for the end-of-conversion flag with a timeout. It then captures the result into a single-entry valid/ready output register. It supports one-shot and continuous conversion, and reports timeout and overrun events.

## Interface
- ADC_BITS, 8, resolution; width of adc_data and out_data
- SAMPLE_CYCLES, 4, clk cycles the sample phase is held high (>=1)
- TIMEOUT_CYCLES, 64, max clk cycles in CONVERT before abort (>=4)
- CNT_W, 8, width of the shared phase/timeout counter; must hold max(SAMPLE_CYCLES, TIMEOUT_CYCLES)

- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-shot conversion request, sampled in IDLE only
- cont_en  in  1  continuous mode: restart sampling after every capture or timeout
- compl  in  1  end-of-conversion flag from the SAR core; asynchronous to clk
- adc_data  in  [0:ADC_BITS-1]  SAR result; index 0 is MSB; stable while compl is high
- sample  out  1  sample/hold track enable
- adc_rst  out  1  active-high reset to the SAR core and async clock generator
- busy  out  1  high whenever the FSM is not IDLE
- out_data  out  ADC_BITS  captured result, MSB at ADC_BITS-1
- out_valid  out  1  out_data holds an unconsumed result
- out_ready  in  1  consumer accepts out_data when high with out_valid
- err_timeout  out  1  one-cycle pulse on conversion abort
- err_overrun  out  1  one-cycle pulse when a result is dropped

## Operation
- Synchronize compl with a 2-flop synchronizer (reset 0) to produce compl_s. Use only compl_s in the FSM.
- IDLE: sample=0, adc_rst=1. If start or cont_en, go to SAMPLE and clear the counter.
- SAMPLE: sample=1, adc_rst=1. The counter increments each cycle. When the counter reaches SAMPLE_CYCLES-1, go to CONVERT and clear the counter.
- CONVERT: sample=0, adc_rst=0. The counter increments each cycle.
  - If compl_s=1, go to CAPTURE.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1, go to IDLE and pulse err_timeout. compl_s has priority if both conditions hold in the same cycle.
- CAPTURE: sample=0, adc_rst=0. Load the result with out_data[ADC_BITS-1-i] = adc_data[i].
  - If out_valid=1 and out_ready=0, drop the new result, keep out_data unchanged and pulse err_overrun.
  - Otherwise load out_data and set out_valid=1.
  - Next state is SAMPLE if cont_en=1, else IDLE.
- Output handshake: out_valid clears on the edge where out_valid and out_ready are both high, unless a capture in the same cycle reloads it.
  - A capture and a consume in the same cycle load the new data, keep out_valid=1 and raise no overrun.
- start asserted outside IDLE is ignored; it is neither queued nor counted.
- Deasserting cont_en mid-conversion finishes the current conversion, then the FSM returns to IDLE.
- A timeout in continuous mode passes through IDLE for one cycle, then resamples because cont_en is still high.

## Timing
- Reset (rst=0) asynchronously forces:
  - FSM to IDLE, counter and synchronizer to 0
  - sample=0, adc_rst=1, busy=0
  - out_valid=0, out_data=0, err_timeout=0, err_overrun=0
- Reset mid-conversion aborts with no error pulse and discards any pending out_data.
- start high at edge E0 (FSM in IDLE): SAMPLE entered at E0, so sample is high for edges E0+1..E0+SAMPLE_CYCLES. CONVERT is entered at edge E0+SAMPLE_CYCLES and adc_rst falls then.
- compl first sampled high at edge N:
  - compl_s=1 after N+1
  - CAPTURE entered at N+2
  - out_valid=1 and out_data updated after N+3
  - adc_rst rises at N+3 when returning to IDLE
- Minimum continuous-mode period: SAMPLE_CYCLES + (conversion cycles) + 3 clk.
- Timeout: adc_rst is low for exactly TIMEOUT_CYCLES cycles, then err_timeout is high for one cycle, coincident with IDLE.
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.

## Test plan
- One-shot, SAMPLE_CYCLES=4: start pulse, compl rises 10 cycles after adc_rst falls, adc_data=8'b1010_0101 -> sample high 4 cycles, out_valid after compl+3 edges, out_data=0xA5, busy returns 0.
- Timeout, TIMEOUT_CYCLES=64: compl held 0 -> adc_rst low exactly 64 cycles, err_timeout one-cycle pulse, out_valid stays 0, FSM in IDLE.
- Continuous mode, out_ready=0: three conversions with results 0x11, 0x22, 0x33 -> out_data stays 0x11, err_overrun pulses twice. Raising out_ready then drops out_valid.
- Simultaneous capture and consume: out_valid=1 and out_ready=1 on the CAPTURE edge with new result 0x7E -> out_data=0x7E, out_valid stays 1, no err_overrun.
- Async reset asserted mid-CONVERT -> adc_rst=1, sample=0, out_valid=0 immediately without a clock edge. After reset release with start=0, the FSM stays in IDLE.
- start pulses during SAMPLE and CONVERT -> ignored, exactly one conversion completes.
